// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the execute stage.
// Produces one quotient bit per cycle; result_o = {remainder, quotient}.
// A request is accepted only from FREE; annul_i aborts an iteration in ON.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  // Two's-complement negation used for operand magnitudes and sign fix-up.
  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W:0]   w_r;        // working register: {remainder, quotient, spare}
  logic [DATA_W-1:0]   divisor_r;  // divisor magnitude captured at acceptance
  logic                neg_quot_r;
  logic                neg_rem_r;

  logic [DATA_W-1:0]   op1_mag_s;
  logic [DATA_W-1:0]   op2_mag_s;
  logic [DATA_W:0]     trial_s;
  logic [2*DATA_W:0]   w_next_s;
  logic [2*DATA_W:0]   w_init_s;
  logic [DATA_W-1:0]   quot_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // Operand magnitudes, one restoring step, and sign-corrected final result.
  always_comb begin
    if (signed_div_i && opdata1_i[DATA_W-1]) begin
      op1_mag_s = neg2c(opdata1_i);
    end else begin
      op1_mag_s = opdata1_i;
    end

    if (signed_div_i && opdata2_i[DATA_W-1]) begin
      op2_mag_s = neg2c(opdata2_i);
    end else begin
      op2_mag_s = opdata2_i;
    end

    w_init_s = {{DATA_W{1'b0}}, op1_mag_s, 1'b0};
    trial_s  = {1'b0, w_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};

    // A borrow means the partial remainder was smaller than the divisor: keep it.
    if (trial_s[DATA_W]) begin
      w_next_s = {w_r[2*DATA_W-1:0], 1'b0};
    end else begin
      w_next_s = {trial_s[DATA_W-1:0], w_r[DATA_W-1:0], 1'b1};
    end

    if (neg_quot_r) begin
      quot_fix_s = neg2c(w_r[DATA_W-1:0]);
    end else begin
      quot_fix_s = w_r[DATA_W-1:0];
    end

    // Remainder follows the sign of the dividend.
    if (neg_rem_r) begin
      rem_fix_s = neg2c(w_r[2*DATA_W:DATA_W+1]);
    end else begin
      rem_fix_s = w_r[2*DATA_W:DATA_W+1];
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_FREE;
      cnt_r      <= CNT_ZERO;
      w_r        <= {(2*DATA_W+1){1'b0}};
      divisor_r  <= {DATA_W{1'b0}};
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_o   <= {(2*DATA_W){1'b0}};
      ready_o    <= 1'b0;
    end else begin
      case (state_r)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= {(2*DATA_W){1'b0}};
          cnt_r    <= CNT_ZERO;
          if (start_i && !annul_i) begin
            if (opdata2_i == {DATA_W{1'b0}}) begin
              state_r <= S_BYZERO;
            end else begin
              state_r    <= S_ON;
              w_r        <= w_init_s;
              divisor_r  <= op2_mag_s;
              neg_quot_r <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_r  <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end else begin
            state_r <= S_FREE;
          end
        end

        // Zero divisor: fixed two-cycle path, then a zero result with ready.
        S_BYZERO: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r   <= CNT_ONE;
            state_r <= S_BYZERO;
          end else begin
            cnt_r    <= CNT_ZERO;
            result_o <= {(2*DATA_W){1'b0}};
            ready_o  <= 1'b1;
            state_r  <= S_END;
          end
        end

        S_ON: begin
          if (annul_i) begin
            state_r  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= {(2*DATA_W){1'b0}};
            cnt_r    <= CNT_ZERO;
          end else if (cnt_r != CNT_DONE) begin
            w_r   <= w_next_s;
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            result_o <= {rem_fix_s, quot_fix_s};
            ready_o  <= 1'b1;
            cnt_r    <= CNT_ZERO;
            state_r  <= S_END;
          end
        end

        // Result is held for as long as EX keeps start_i asserted.
        S_END: begin
          if (!start_i) begin
            state_r  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= {(2*DATA_W){1'b0}};
          end else begin
            state_r <= S_END;
          end
        end

        default: begin
          state_r  <= S_FREE;
          cnt_r    <= CNT_ZERO;
          ready_o  <= 1'b0;
          result_o <= {(2*DATA_W){1'b0}};
        end
      endcase
    end
  end

endmodule
